// File: rtl/class_tree_pkg.sv
// Shared field-width helpers, decoded node layout and FSM state encoding for the
// decision-tree classification engine.
package class_tree_pkg;

  // Decoded node fields are zero-extended to this width, independent of parameters.
  localparam int unsigned MaxFieldW = 16;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned node_w(input int unsigned n_feat,
                                         input int unsigned n_nodes,
                                         input int unsigned class_w);
    return 1 + idx_w(n_feat) + idx_w(n_nodes) + idx_w(n_nodes) + class_w;
  endfunction

  typedef struct packed {
    logic                 is_leaf;
    logic [MaxFieldW-1:0] feat_idx;
    logic [MaxFieldW-1:0] true_child;
    logic [MaxFieldW-1:0] false_child;
    logic [MaxFieldW-1:0] leaf_class;
  } node_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWalk = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/class_tree_node_mem.sv
// Node table: one synchronous write port, one asynchronous read port, no reset
// (contents are undefined until written).
module class_tree_node_mem #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 20,
  parameter int unsigned AddrW = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/class_tree_engine.sv
// Decision-tree classifier: walks one node per cycle from the root at address 0
// until a leaf, an out-of-range feature index, or the depth limit is hit.
module class_tree_engine
  import class_tree_pkg::*;
#(
  parameter int unsigned N_FEAT    = 51,
  parameter int unsigned N_NODES   = 64,
  parameter int unsigned CLASS_W   = 1,
  parameter int unsigned MAX_DEPTH = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [N_FEAT-1:0]                         i,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  output logic [CLASS_W-1:0]                        o,
  output logic                                      o_err,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  input  logic                                      cfg_we,
  input  logic [idx_w(N_NODES)-1:0]                 cfg_addr,
  input  logic [node_w(N_FEAT, N_NODES, CLASS_W)-1:0] cfg_wdata,
  output logic                                      cfg_busy
);

  localparam int unsigned FeatW  = idx_w(N_FEAT);
  localparam int unsigned AddrW  = idx_w(N_NODES);
  localparam int unsigned NodeW  = node_w(N_FEAT, N_NODES, CLASS_W);
  localparam int unsigned DepthW = idx_w(MAX_DEPTH);

  localparam logic [MaxFieldW-1:0] FeatLimit = MaxFieldW'(N_FEAT);
  localparam logic [DepthW-1:0]    DepthLast = DepthW'(MAX_DEPTH - 1);

  state_e              state_q, state_d;
  logic [AddrW-1:0]    cur_q, cur_d;
  logic [DepthW-1:0]   depth_q, depth_d;
  logic [N_FEAT-1:0]   feat_q, feat_d;
  logic [CLASS_W-1:0]  o_q, o_d;
  logic                err_q, err_d;

  logic [NodeW-1:0]    rdata;
  logic                mem_we;
  node_t               node;
  logic                feat_ok;
  logic                feat_bit;
  logic [AddrW-1:0]    next_child;

  assign mem_we = cfg_we && (state_q == StIdle);

  class_tree_node_mem #(
    .Depth(N_NODES),
    .Width(NodeW),
    .AddrW(AddrW)
  ) u_node_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(cfg_addr),
    .wdata(cfg_wdata),
    .raddr(cur_q),
    .rdata(rdata)
  );

  // Word layout, MSB first: is_leaf, feat_idx, true_child, false_child, leaf_class.
  always_comb begin
    node = '0;
    node.is_leaf                   = rdata[NodeW-1];
    node.feat_idx[FeatW-1:0]       = rdata[CLASS_W + AddrW + AddrW +: FeatW];
    node.true_child[AddrW-1:0]     = rdata[CLASS_W + AddrW +: AddrW];
    node.false_child[AddrW-1:0]    = rdata[CLASS_W +: AddrW];
    node.leaf_class[CLASS_W-1:0]   = rdata[CLASS_W-1:0];
  end

  assign feat_ok    = node.feat_idx < FeatLimit;
  assign feat_bit   = feat_ok ? feat_q[node.feat_idx[FeatW-1:0]] : 1'b0;
  assign next_child = feat_bit ? node.true_child[AddrW-1:0] : node.false_child[AddrW-1:0];

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    depth_d = depth_q;
    feat_d  = feat_q;
    o_d     = o_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          feat_d  = i;
          cur_d   = '0;
          depth_d = '0;
          state_d = StWalk;
        end
      end
      StWalk: begin
        if (node.is_leaf) begin
          o_d     = node.leaf_class[CLASS_W-1:0];
          err_d   = 1'b0;
          state_d = StDone;
        end else if (!feat_ok || (depth_q == DepthLast)) begin
          o_d     = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cur_d   = next_child;
          depth_d = depth_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cur_q   <= '0;
      depth_q <= '0;
      feat_q  <= '0;
      o_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      depth_q <= depth_d;
      feat_q  <= feat_d;
      o_q     <= o_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign cfg_busy  = (state_q != StIdle);
  assign o         = o_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_class_tree_engine.sv
// Directed bench for class_tree_engine with default parameters (20-bit node word).
module tb_class_tree_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [50:0] i;
  logic        in_valid;
  logic        in_ready;
  logic [0:0]  o;
  logic        o_err;
  logic        out_valid;
  logic        out_ready;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [19:0] cfg_wdata;
  logic        cfg_busy;

  int checks   = 0;
  int failures = 0;

  class_tree_engine dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i        (i),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .o        (o),
    .o_err    (o_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_busy (cfg_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] mk(input bit leaf, input int feat, input int t, input int f,
                                     input int c);
    logic [5:0] fe, tc, fc;
    logic [0:0] cl;
    fe = 6'(feat);
    tc = 6'(t);
    fc = 6'(f);
    cl = 1'(c);
    return {leaf, fe, tc, fc, cl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input logic [19:0] word);
    cfg_we    = 1'b1;
    cfg_addr  = 6'(addr);
    cfg_wdata = word;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic accept(input logic [50:0] vec);
    i        = vec;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic load_basic();
    cfg_write(0, mk(1'b0, 42, 1, 2, 0));
    cfg_write(1, mk(1'b1, 0, 0, 0, 1));
    cfg_write(2, mk(1'b1, 0, 0, 0, 0));
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cfg_busy !== 1'b0 || o !== 1'b0 ||
        o_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b cfg_busy=%b o=%b o_err=%b, want 0 1 0 0 0",
               out_valid, in_ready, cfg_busy, o, o_err);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_true_path();
    int n;
    logic [50:0] v;
    load_basic();
    v = '0;
    v[42] = 1'b1;
    accept(v);
    checks++;
    if (cfg_busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL walk_flags: cfg_busy=%b in_ready=%b, want 1 0", cfg_busy, in_ready);
    end
    wait_done(n);
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL true_latency: got %0d cycles, want 2", n);
    end
    checks++;
    if (o !== 1'b1 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL true_result: o=%b o_err=%b, want 1 0", o, o_err);
    end
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL true_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_false_hold();
    int n;
    accept('0);
    wait_done(n);
    checks++;
    if (n !== 2 || o !== 1'b0 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL false_result: cycles=%0d o=%b o_err=%b, want 2 0 0", n, o, o_err);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || o !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_%0d: out_valid=%b o=%b in_ready=%b, want 1 0 0",
                 k, out_valid, o, in_ready);
      end
    end
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_depth_limit();
    int n;
    cfg_write(0, mk(1'b0, 0, 0, 0, 0));
    accept('1);
    wait_done(n);
    checks++;
    if (n !== 16 || o !== 1'b0 || o_err !== 1'b1) begin
      failures++;
      $display("FAIL depth_limit: cycles=%0d o=%b o_err=%b, want 16 0 1", n, o, o_err);
    end
    release_result();
  endtask

  task automatic test_bad_feat();
    int n;
    cfg_write(0, mk(1'b0, 60, 1, 2, 0));
    accept('1);
    wait_done(n);
    checks++;
    if (n !== 1 || o !== 1'b0 || o_err !== 1'b1) begin
      failures++;
      $display("FAIL bad_feat: cycles=%0d o=%b o_err=%b, want 1 0 1", n, o, o_err);
    end
    release_result();
  endtask

  task automatic test_same_cycle_write();
    int n;
    // Root currently holds a bad feature index; the concurrent write must win.
    cfg_we    = 1'b1;
    cfg_addr  = 6'd0;
    cfg_wdata = mk(1'b1, 0, 0, 0, 1);
    accept('0);
    cfg_we    = 1'b0;
    wait_done(n);
    checks++;
    if (n !== 1 || o !== 1'b1 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_write: cycles=%0d o=%b o_err=%b, want 1 1 0", n, o, o_err);
    end
    release_result();
  endtask

  task automatic test_cfg_drop();
    int n;
    logic [50:0] v;
    load_basic();
    v = '0;
    v[42] = 1'b1;
    accept(v);
    cfg_write(1, mk(1'b1, 0, 0, 0, 0));
    wait_done(n);
    checks++;
    if (n !== 1 || o !== 1'b1 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL cfg_drop_walk: cycles_left=%0d o=%b o_err=%b, want 1 1 0", n, o, o_err);
    end
    // Write while DONE must also be dropped.
    cfg_write(1, mk(1'b1, 0, 0, 0, 0));
    release_result();
    accept(v);
    wait_done(n);
    checks++;
    if (n !== 2 || o !== 1'b1) begin
      failures++;
      $display("FAIL cfg_drop_done: cycles=%0d o=%b, want 2 1", n, o);
    end
    release_result();
  endtask

  task automatic test_reset_mid_walk();
    int seen;
    cfg_write(0, mk(1'b0, 0, 0, 0, 0));
    accept('1);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cfg_busy !== 1'b0 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: out_valid=%b in_ready=%b cfg_busy=%b o_err=%b, want 0 1 0 0",
               out_valid, in_ready, cfg_busy, o_err);
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_abort: out_valid_cycles=%0d in_ready=%b, want 0 1", seen, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [50:0] v;
    load_basic();
    out_ready = 1'b1;
    v = '0;
    v[42] = 1'b1;
    accept(v);
    wait_done(n);
    tick();
    accept('0);
    wait_done(n);
    checks++;
    if (n !== 2 || o !== 1'b0 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back: cycles=%0d o=%b o_err=%b, want 2 0 0", n, o, o_err);
    end
    out_ready = 1'b0;
    release_result();
  endtask

  initial begin
    rst_n     = 1'b0;
    i         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    #12;
    test_reset();
    test_true_path();
    test_false_hold();
    test_depth_limit();
    test_bad_feat();
    test_same_cycle_write();
    test_cfg_drop();
    test_reset_mid_walk();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
